// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   Byte-wide SPI master (sclk idles low; the slave drives miso on the sclk
//   rise and samples mosi on the sclk fall). A byte is shifted MSB-first on
//   mosi while the slave's byte is captured from miso.
//
//   Parameter
//     CLK_DIV : sclk half-period in clk cycles (>= 1)
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-high reset
//     start  in   transfer request, sampled only while idle
//     din    in   [7:0] byte to transmit, captured on the accepting edge
//     dout   out  [7:0] last received byte, updated with done
//     busy   out  high from acceptance through the end of the inter-frame gap
//     done   out  one-cycle pulse when dout is updated
//     sclk   out  SPI clock, idle low
//     cs     out  chip select, active low
//     mosi   out  serial data to slave
//     miso   in   serial data from slave, synchronous to clk
//
//   Build option
//     SPI_MASTER_EXTRA_CLK_EN : emit a 9th sclk pulse (mosi held 0, miso not
//     sampled) after the data bits so slaves that commit on a 9th fall can.
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef SPI_MASTER_EXTRA_CLK_EN
    localparam logic [3:0] FALLS = 4'd9;
`else
    localparam logic [3:0] FALLS = 4'd8;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;       // cycles within the current half-period
    logic [3:0]    bitcnt, bitcnt_nxt; // sclk falls seen in this frame
    logic [6:0]    tx, tx_nxt;         // bits still to send; bit 7 goes out on accept
    logic [7:0]    rx, rx_nxt;
    logic [7:0]    dout_nxt;
    logic          busy_nxt, done_nxt, sclk_nxt, cs_nxt, mosi_nxt;
    logic          tick;
    logic          accept;

    assign tick = (cnt == CNT_LAST);

    // The end of GAP doubles as an accepting edge so back-to-back frames are
    // exactly 18*CLK_DIV cycles apart with CLK_DIV cycles of cs high between.
    assign accept = start && ((state == IDLE) || (state == GAP && tick));

    // State and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            tx     <= '0;
            rx     <= '0;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sclk   <= 1'b0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bitcnt <= bitcnt_nxt;
            tx     <= tx_nxt;
            rx     <= rx_nxt;
            dout   <= dout_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            sclk   <= sclk_nxt;
            cs     <= cs_nxt;
            mosi   <= mosi_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = SHIFT;
            SHIFT:   if (tick && sclk && bitcnt == FALLS - 4'd1) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = GAP;
            GAP:     if (tick) state_nxt = start ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and outputs.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        cnt_nxt    = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        bitcnt_nxt = bitcnt;
        tx_nxt     = tx;
        rx_nxt     = rx;
        dout_nxt   = dout;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        sclk_nxt   = sclk;
        cs_nxt     = cs;
        mosi_nxt   = mosi;

        case (state)
            SETUP: if (tick) sclk_nxt = 1'b1;
            SHIFT: if (tick) begin
                sclk_nxt = ~sclk;
                if (sclk) begin
                    bitcnt_nxt = bitcnt + 4'd1;
                    // Falls beyond the 8th (extra pulse) neither sample nor shift.
                    if (bitcnt < 4'd8) begin
                        rx_nxt   = {rx[6:0], miso};
                        tx_nxt   = {tx[5:0], 1'b0};
                        mosi_nxt = (bitcnt == 4'd7) ? 1'b0 : tx[6];
                    end
                end
            end
            HOLD: if (tick) begin
                cs_nxt   = 1'b1;
                dout_nxt = rx;
                done_nxt = 1'b1;
            end
            GAP: if (tick) busy_nxt = 1'b0;
            default: ;
        endcase

        if (accept) begin
            tx_nxt     = din[6:0];
            bitcnt_nxt = '0;
            cs_nxt     = 1'b0;
            busy_nxt   = 1'b1;
            mosi_nxt   = din[7];
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master. u_dut (CLK_DIV=2) talks to a behavioural
//   SPI slave that returns 0x3C and records the bits it samples on mosi;
//   u_dut1 (CLK_DIV=1) runs with miso tied high. Expected values and cycle
//   offsets are written out by hand from the frame timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

`ifdef SPI_MASTER_EXTRA_CLK_EN
    localparam int DONE_HP = 19;   // done offset in sclk half-periods
    localparam int RISES   = 9;
`else
    localparam int DONE_HP = 17;
    localparam int RISES   = 8;
`endif

    logic       clk, reset;
    logic       start, start1;
    logic [7:0] din, din1;
    logic [7:0] dout, dout1;
    logic       busy, busy1, done, done1, sclk, sclk1, cs, cs1, mosi, mosi1;
    logic       miso;

    int n_cmp = 0;
    int n_err = 0;

    spi_master #(.CLK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .dout(dout),
        .busy(busy), .done(done), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .din(din1), .dout(dout1),
        .busy(busy1), .done(done1), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave, evaluated mid-cycle so it sees settled DUT outputs.
    logic [7:0] s_pattern = 8'h3C;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00, s_commit = 8'h00;
    logic       s_hold = 1'b0, cs_d = 1'b1, sclk_d = 1'b0;
    int         s_rises = 0, s_falls = 0, done_cnt = 0;

    initial miso = 1'b0;

    always @(negedge clk) begin
        if (!cs && cs_d) begin
            s_tx = s_pattern; s_rx = 8'h00; s_rises = 0; s_falls = 0;
        end
        if (sclk && !sclk_d) begin
            s_rises++;
            miso = s_tx[7];
            s_tx = {s_tx[6:0], 1'b0};
        end
        if (!sclk && sclk_d) begin
            s_falls++;
            if (s_falls <= 8) s_rx = {s_rx[6:0], s_hold};
            else if (s_falls == 9) s_commit = s_rx;
        end
        if (sclk) s_hold = mosi;   // value present while sclk high = value at the fall
        if (done) done_cnt++;
        cs_d = cs; sclk_d = sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    int n, toggles, done_snap;
    logic prev;

    initial begin
        reset = 1'b1; start = 1'b0; din = 8'h00; start1 = 1'b0; din1 = 8'h00;
        wait_clk(); wait_clk();
        check("rst_sclk", sclk, 1'b0);
        check("rst_cs",   cs,   1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        wait_clk();

        // Basic exchange: 0xA5 out, 0x3C back.
        start = 1'b1; din = 8'hA5;
        wait_clk();                          // E0
        start = 1'b0;
        check("t1_cs_at_e0",   cs,   1'b0);
        check("t1_busy_at_e0", busy, 1'b1);
        check("t1_mosi_bit7",  mosi, 1'b1);
        n = 0;
        do begin wait_clk(); n++; end while (!done && n < 80);
        check("t1_done_cycle", n, DONE_HP * 2);
        check("t1_dout",       dout, 8'h3C);
        check("t1_cs_at_done", cs, 1'b1);
        check("t1_sclk_rises", s_rises, RISES);
        check("t1_mosi_bits",  s_rx, 8'hA5);
`ifdef SPI_MASTER_EXTRA_CLK_EN
        check("t1_slave_commit", s_commit, 8'hA5);
`endif
        do begin wait_clk(); n++; end while (busy && n < 80);
        check("t1_busy_fall", n, (DONE_HP + 1) * 2);
        check("t1_done_once", done_cnt, 1);

        // Start held high, din changed mid-frame; frames run back-to-back.
        start = 1'b1; din = 8'hA5;
        wait_clk();                          // E0
        for (int i = 0; i < 10; i++) wait_clk();
        din = 8'hFF;
        n = 0;
        do begin wait_clk(); n++; end while (!done && n < 80);
        check("t3_tx_kept",  s_rx, 8'hA5);
        check("t3_dout",     dout, 8'h3C);
        n = 0;
        do begin wait_clk(); n++; end while (cs && n < 20);
        check("t3_gap_cycles", n, 2);
        check("t3_busy_held",  busy, 1'b1);
        start = 1'b0;
        n = 0;
        do begin wait_clk(); n++; end while (!done && n < 80);
        check("t3_frame2_tx", s_rx, 8'hFF);
        n = 0;
        do begin wait_clk(); n++; end while (busy && n < 20);
        check("t3_idle_after", busy, 1'b0);

        // Reset after the 3rd sclk fall.
        start = 1'b1; din = 8'hA5;
        wait_clk();
        start = 1'b0;
        n = 0;
        do begin wait_clk(); n++; end while (s_falls != 3 && n < 80);
        check("t4_reached_fall3", s_falls, 3);
        done_snap = done_cnt;
        reset = 1'b1;
        #1;
        check("t4_cs",   cs,   1'b1);
        check("t4_sclk", sclk, 1'b0);
        check("t4_mosi", mosi, 1'b0);
        check("t4_dout", dout, 8'h00);
        check("t4_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) wait_clk();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) wait_clk();
        check("t4_no_done", done_cnt, done_snap);
        check("t4_stay_idle", busy, 1'b0);

        // Minimum divider on u_dut1, miso tied high.
        start1 = 1'b1; din1 = 8'h81;
        wait_clk();                          // E0
        start1 = 1'b0;
        check("t5_mosi_bit7", mosi1, 1'b1);
        n = 0; toggles = 0; prev = sclk1;
        do begin
            wait_clk(); n++;
            if (n <= 16 && sclk1 != prev) toggles++;
            prev = sclk1;
        end while (!done1 && n < 40);
        check("t5_toggles",   toggles, 16);
        check("t5_done_cycle", n, DONE_HP);
        check("t5_dout",      dout1, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
